// File: rtl/within_chk_pkg.sv
// within_chk_pkg: shared FSM state and failure-cause encodings for the within checker.
package within_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE      = 3'd0,
        FC_NO_START  = 3'd1,
        FC_C_TIMEOUT = 3'd2,
        FC_A_MISS    = 3'd3,
        FC_EARLY_C   = 3'd4
    } fail_code_t;

endpackage

// File: rtl/within_chk_ch.sv
// within_chk_ch: one channel checking that inner event a lands inside the outer b..c sequence.
module within_chk_ch
    import within_chk_pkg::*;
#(
    parameter int A_MIN = 1,
    parameter int A_MAX = 2,
    parameter int C_MIN = 3,
    parameter int C_MAX = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       trig,
    input  logic       b,
    input  logic       a,
    input  logic       c,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [2:0] fail_code,
    output logic       overlap
);

    localparam int K_TOP = (A_MAX > C_MAX ? A_MAX : C_MAX) + 1;
    localparam int K_W = $clog2(K_TOP + 1);
    localparam logic [K_W-1:0] KA_LO = K_W'(A_MIN);
    localparam logic [K_W-1:0] KA_HI = K_W'(A_MAX);
    localparam logic [K_W-1:0] KC_LO = K_W'(C_MIN);
    localparam logic [K_W-1:0] KC_HI = K_W'(C_MAX);

    state_t         state, state_nx;
    fail_code_t     code_nx;
    logic [K_W-1:0] k, k_nx;
    logic           a_ok, a_ok_nx, trig_q;
    logic           rise, run, a_hit, c_hit, dec_pass, dec_fail, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            a_ok      <= 1'b0;
            trig_q    <= 1'b1;
            pass      <= 1'b0;
            fail      <= 1'b0;
            overlap   <= 1'b0;
            fail_code <= FC_NONE;
        end else begin
            state   <= state_nx;
            k       <= k_nx;
            a_ok    <= a_ok_nx;
            trig_q  <= trig;
            pass    <= dec_pass;
            fail    <= dec_fail;
            overlap <= rise && state != ST_IDLE;
            if (dec_fail) fail_code <= code_nx;
        end
    end

    // c-window match outranks a-miss, which outranks the c timeout
    always_comb begin
        rise     = trig && !trig_q;
        run      = state == ST_RUN;
        a_hit    = run && a && k >= KA_LO && k <= KA_HI;
        c_hit    = run && c && k >= KC_LO && k <= KC_HI;
        dec_pass = c_hit && (a_ok || a_hit);
        code_nx  = (state == ST_START && !b) ? FC_NO_START :
                   c_hit                     ? FC_EARLY_C :
                   (run && !a_ok && k > KA_HI) ? FC_A_MISS :
                   (run && k == KC_HI)       ? FC_C_TIMEOUT : FC_NONE;
        dec_fail = code_nx != FC_NONE && !dec_pass;
        done     = dec_pass || dec_fail;
        state_nx = state == ST_IDLE  ? ((rise && en) ? ST_START : ST_IDLE) :
                   state == ST_START ? (b ? ST_RUN : ST_IDLE) :
                   done              ? ST_IDLE : ST_RUN;
        k_nx     = (state == ST_START && b) ? K_W'(1) : (run && !done) ? k + 1'b1 : '0;
        a_ok_nx  = run && !done && (a_ok || a_hit);
    end

    always_comb begin
        busy = state != ST_IDLE;
    end

endmodule

// File: rtl/within_checker.sv
// within_checker: N_CH independent within-sequence checkers with shared saturating verdict counters.
module within_checker
    import within_chk_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int A_MIN = 1,
    parameter int A_MAX = 2,
    parameter int C_MIN = 3,
    parameter int C_MAX = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CH-1:0]   trig,
    input  logic [N_CH-1:0]   b,
    input  logic [N_CH-1:0]   a,
    input  logic [N_CH-1:0]   c,
    output logic [N_CH-1:0]   busy,
    output logic [N_CH-1:0]   pass,
    output logic [N_CH-1:0]   fail,
    output logic [3*N_CH-1:0] fail_code,
    output logic [N_CH-1:0]   overlap,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    if (N_CH < 1 || A_MIN < 1 || A_MIN > A_MAX || C_MIN < 1 || C_MIN > C_MAX || A_MIN > C_MAX) begin : g_bad_params
        $error("within_checker: illegal window parameters");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        within_chk_ch #(
            .A_MIN(A_MIN),
            .A_MAX(A_MAX),
            .C_MIN(C_MIN),
            .C_MAX(C_MAX)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .trig     (trig[i]),
            .b        (b[i]),
            .a        (a[i]),
            .c        (c[i]),
            .busy     (busy[i]),
            .pass     (pass[i]),
            .fail     (fail[i]),
            .fail_code(fail_code[3*i +: 3]),
            .overlap  (overlap[i])
        );
    end

    // sums carry enough headroom that saturation is a plain compare
    localparam int S_W = CNT_W + $clog2(N_CH + 1);
    localparam logic [S_W-1:0] CNT_TOP = S_W'({CNT_W{1'b1}});

    logic [S_W-1:0] pass_sum, fail_sum;

    always_comb begin
        pass_sum = S_W'(pass_cnt);
        fail_sum = S_W'(fail_cnt);
        for (int j = 0; j < N_CH; j++) begin
            pass_sum = pass_sum + S_W'(pass[j]);
            fail_sum = fail_sum + S_W'(fail[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            pass_cnt <= pass_sum > CNT_TOP ? '1 : pass_sum[CNT_W-1:0];
            fail_cnt <= fail_sum > CNT_TOP ? '1 : fail_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_within_checker.sv
// tb_within_checker: directed checks with a pulse scoreboard; a narrow-counter twin exercises saturation.
module tb_within_checker;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [3:0]  trig, b, a, c;
    logic [3:0]  busy, pass, fail, overlap;
    logic [11:0] fail_code;
    logic [15:0] pass_cnt, fail_cnt;
    logic [3:0]  s_busy, s_pass, s_fail, s_overlap;
    logic [11:0] s_fail_code;
    logic [2:0]  s_pass_cnt, s_fail_cnt;

    typedef struct {
        int          cyc;
        logic [3:0]  p;
        logic [3:0]  f;
        logic [3:0]  o;
        logic [11:0] code;
    } ev_t;

    ev_t         sb[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          exp_pass = 0;
    int          exp_fail = 0;
    logic [11:0] codes = '0;
    bit          mon_en = 1'b0;

    within_checker dut (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .b(b), .a(a), .c(c),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code), .overlap(overlap),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    within_checker #(.CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .en(en), .trig(trig), .b(b), .a(a), .c(c),
        .busy(s_busy), .pass(s_pass), .fail(s_fail), .fail_code(s_fail_code), .overlap(s_overlap),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int dt, input logic [3:0] p, input logic [3:0] f, input logic [3:0] o);
        sb.push_back('{cyc + dt, p, f, o, codes});
    endtask

    task automatic set_code(input int ch, input logic [2:0] v);
        codes[3*ch +: 3] = v;
    endtask

    task automatic cnt_check;
        check("pass_cnt", pass_cnt, exp_pass);
        check("fail_cnt", fail_cnt, exp_fail);
        check("small_pass_cnt", s_pass_cnt, exp_pass > 7 ? 7 : exp_pass);
        check("small_fail_cnt", s_fail_cnt, exp_fail > 7 ? 7 : exp_fail);
    endtask

    // step j: j=0 rise, j=1 START (b), j>=2 RUN at offset k=j-1 driven from av[k]/cv[k]
    task automatic run(input logic [3:0] m, input logic bv, input logic [7:0] tv,
                       input logic [7:0] av, input logic [7:0] cv, input int len);
        for (int j = 0; j < len; j++) begin
            trig = tv[j] ? m : 4'b0;
            b    = (j == 1 && bv) ? m : 4'b0;
            a    = (j >= 2 ? av[j-1] : 1'b0) ? m : 4'b0;
            c    = (j >= 2 ? cv[j-1] : 1'b0) ? m : 4'b0;
            tick;
            if (j == 0) check("busy_arm", busy & m, en ? m : 4'b0);
        end
        trig = '0; b = '0; a = '0; c = '0;
        tick;
        check("busy_done", busy, 4'b0);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("fail_code", fail_code, e.code);
            end else begin
                e = '{cyc, 4'b0, 4'b0, 4'b0, 12'b0};
            end
            check("pulses", {pass, fail, overlap}, {e.p, e.f, e.o});
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; trig = '0; b = '0; a = '0; c = '0;
        tick; tick;
        mon_en = 1'b1;
        tick;
        check("rst_busy", busy, 4'b0);
        check("rst_code", fail_code, 12'b0);
        cnt_check;
        rst = 1'b0;
        tick; tick;
        // a at k=2, c at k=4
        expect_ev(6, 4'b0001, 4'b0, 4'b0);
        run(4'b0001, 1'b1, 8'b1, 8'b100, 8'b10000, 6);
        exp_pass = 1; cnt_check;
        // b missing at START
        set_code(0, 3'd1);
        expect_ev(2, 4'b0, 4'b0001, 4'b0);
        run(4'b0001, 1'b0, 8'b1, 8'b0, 8'b0, 2);
        exp_fail = 1; cnt_check;
        // a at k=1, c at k=3
        expect_ev(5, 4'b0001, 4'b0, 4'b0);
        run(4'b0001, 1'b1, 8'b1, 8'b10, 8'b1000, 5);
        exp_pass = 2;
        // a only at k=3 is outside the window
        set_code(0, 3'd3);
        expect_ev(5, 4'b0, 4'b0001, 4'b0);
        run(4'b0001, 1'b1, 8'b1, 8'b1000, 8'b0, 5);
        exp_fail = 2;
        // c never arrives
        set_code(0, 3'd2);
        expect_ev(7, 4'b0, 4'b0001, 4'b0);
        run(4'b0001, 1'b1, 8'b1, 8'b10, 8'b0, 7);
        exp_fail = 3;
        // early c at k=2 ignored, c at k=4 decides
        expect_ev(6, 4'b0001, 4'b0, 4'b0);
        run(4'b0001, 1'b1, 8'b1, 8'b100, 8'b10100, 6);
        exp_pass = 3;
        // c in window without any a: early-c wins over a-miss
        set_code(0, 3'd4);
        expect_ev(5, 4'b0, 4'b0001, 4'b0);
        run(4'b0001, 1'b1, 8'b1, 8'b0, 8'b1000, 5);
        exp_fail = 4; cnt_check;
        // second rise at k=2
        expect_ev(4, 4'b0, 4'b0, 4'b0001);
        expect_ev(6, 4'b0001, 4'b0, 4'b0);
        run(4'b0001, 1'b1, 8'b1001, 8'b100, 8'b10000, 6);
        exp_pass = 4;
        // en low blocks arming
        en = 1'b0;
        run(4'b0001, 1'b1, 8'b1, 8'b100, 8'b10000, 6);
        en = 1'b1;
        cnt_check;
        // all four channels pass together
        expect_ev(6, 4'b1111, 4'b0, 4'b0);
        run(4'b1111, 1'b1, 8'b1, 8'b100, 8'b10000, 6);
        exp_pass = 8; cnt_check;
        // channel 2 failure lands in its own code slice
        set_code(2, 3'd1);
        expect_ev(2, 4'b0, 4'b0100, 4'b0);
        run(4'b0100, 1'b0, 8'b1, 8'b0, 8'b0, 2);
        exp_fail = 5;
        // narrow counter stays saturated
        expect_ev(7, 4'b0001, 4'b0, 4'b0);
        run(4'b0001, 1'b1, 8'b1, 8'b100, 8'b100000, 7);
        exp_pass = 9; cnt_check;
        // re-arm in the cycle the verdict pulses
        set_code(0, 3'd1);
        expect_ev(2, 4'b0, 4'b0001, 4'b0);
        expect_ev(4, 4'b0, 4'b0001, 4'b0);
        trig = 4'b0001; tick;
        trig = 4'b0; tick;
        trig = 4'b0001; tick;
        check("rearm_busy", busy, 4'b0001);
        trig = 4'b0; tick;
        tick;
        exp_fail = 7; cnt_check;
        // reset mid-check with trig held high across release
        trig = 4'b0001; tick;
        trig = 4'b0; b = 4'b0001; tick;
        b = 4'b0; tick;
        a = 4'b0001; tick;
        a = 4'b0; rst = 1'b1; trig = 4'b0001;
        tick;
        codes = '0; exp_pass = 0; exp_fail = 0;
        check("rst_mid_busy", busy, 4'b0);
        check("rst_mid_out", {pass, fail, overlap}, 12'b0);
        check("rst_mid_code", fail_code, 12'b0);
        cnt_check;
        tick;
        rst = 1'b0;
        tick; tick; tick;
        check("held_trig_busy", busy, 4'b0);
        trig = 4'b0; tick;
        check("post_rst_busy", busy, 4'b0);
        expect_ev(6, 4'b0001, 4'b0, 4'b0);
        run(4'b0001, 1'b1, 8'b1, 8'b100, 8'b10000, 6);
        exp_pass = 1; cnt_check;
        tick;
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/within_checker.md
WITHIN_CHECKER -- requirements
Module: within_checker

Interface
REQ-001 Parameter N_CH, default 4: number of independent checker channels.
REQ-002 Parameter A_MIN, default 1: earliest inner-sequence (a) offset from window start.
REQ-003 Parameter A_MAX, default 2: latest inner-sequence (a) offset.
REQ-004 Parameter C_MIN, default 3: earliest outer-sequence end (c) offset.
REQ-005 Parameter C_MAX, default 5: latest outer-sequence end (c) offset.
REQ-006 Parameter CNT_W, default 16: width of the verdict counters.
REQ-007 clk  in  1  sole clock, all state on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 en  in  1  global enable; 0 blocks new triggers, in-flight checks continue.
REQ-010 trig  in  N_CH  per-channel antecedent; a rising edge arms a check.
REQ-011 b  in  N_CH  per-channel outer-sequence start condition.
REQ-012 a  in  N_CH  per-channel inner-sequence event.
REQ-013 c  in  N_CH  per-channel outer-sequence end event.
REQ-014 busy  out  N_CH  channel is evaluating a check.
REQ-015 pass  out  N_CH  one-cycle pass pulse.
REQ-016 fail  out  N_CH  one-cycle fail pulse.
REQ-017 fail_code  out  3*N_CH  cause of last failure, channel i in bits [3i+2:3i].
REQ-018 overlap  out  N_CH  one-cycle pulse: rising trig ignored while busy.
REQ-019 pass_cnt, fail_cnt  out  CNT_W each  saturating totals over all channels.

Function
REQ-020 Elaboration SHALL reject parameters unless 1<=A_MIN<=A_MAX, 1<=C_MIN<=C_MAX, A_MIN<=C_MAX, N_CH>=1.
REQ-021 Rising edge SHALL be trig=1 with the registered previous trig=0, sampled at cycle t.
REQ-022 Per-channel FSM states: IDLE, START, RUN.
REQ-023 IDLE->START on rising edge with en=1; otherwise stays IDLE.
REQ-024 START (cycle t+1, offset k=0): b=0 -> fail NO_START (code 1), go IDLE; b=1 -> RUN, k increments each cycle from 1.
REQ-025 RUN: a=1 with A_MIN<=k<=A_MAX sets a_ok; a outside the window is ignored.
REQ-026 RUN: the first c=1 with C_MIN<=k<=C_MAX ends the outer sequence (first-match); c outside the window is ignored.
REQ-027 At that c: a_ok=1, or a=1 in the same cycle with k in the a-window -> pass; otherwise fail EARLY_C (code 4). Either way go IDLE.
REQ-028 k>A_MAX with a_ok=0 and no decision yet -> fail A_MISS (code 3) immediately, go IDLE.
REQ-029 k=C_MAX with no c -> fail C_TIMEOUT (code 2), go IDLE.
REQ-030 If several rules apply in one cycle, priority is REQ-027, then REQ-028, then REQ-029.
REQ-031 pass/fail SHALL pulse exactly one cycle, in the cycle after the deciding sample; pass and fail are never both high on a channel.
REQ-032 fail_code SHALL update only on fail and hold otherwise; code 0 means no failure since reset.
REQ-033 Rising trig while START or RUN SHALL be ignored and pulse overlap for one cycle.
REQ-034 A new check MAY arm in the cycle the verdict pulses.
REQ-035 busy=1 in START and RUN.
REQ-036 Counters SHALL add the popcount of pass (or fail) each cycle and saturate at all-ones; wrap-around is forbidden.

Reset
REQ-037 rst SHALL force every FSM to IDLE and clear k, a_ok, busy, pass, fail, overlap, fail_code and both counters, including mid-check.
REQ-038 The previous-trig register SHALL reset to 1, so trig held high through reset never arms.

Structure
REQ-039 Package within_chk_pkg holds the FSM state enum and the fail-code enum (NONE=0, NO_START=1, C_TIMEOUT=2, A_MISS=3, EARLY_C=4).
REQ-040 Sub-module within_chk_ch implements one channel; the top generates N_CH instances and the shared saturating counters.

Verification (default parameters, channel 0 unless stated)
REQ-041 Rise at t, b=1 at t+1, a at k=2, c at k=4 -> pass at k=5, pass_cnt=1.
REQ-042 Rise at t, b=0 at t+1 -> fail at t+2, code 1; a=1 at k=1 and c=1 at k=3 -> pass; a=1 only at k=3 -> fail at k=4 (decided at k=3), code 3.
REQ-043 a at k=1, c never -> fail at k=6 (decided at k=5), code 2; a at k=2, c at k=2 then c at k=4 -> pass at k=5 (k=2 c ignored).
REQ-044 Second rise at k=2 of a running check -> overlap pulse, first check still passes, no second check starts.
REQ-045 rst asserted at k=3 -> all outputs 0 next cycle; trig held high through reset release -> no arm; counters forced to all-ones stay saturated on further passes.
REQ-046 All 4 channels pass in the same cycle -> pass_cnt increments by 4.
